wave_param_loader: RTL and testbench
====================================

# wave_param_loader

Byte-stream configuration front end for the four-channel wave generator. Decodes framed write, commit and clear commands from an 8-bit valid/ready stream into per-channel shadow registers. Copies all shadows to the active amplitude, offset and phase-word buses in a single cycle, so the four channels of the summing block always change on the same edge. Sits between the host/UART byte source and the channel-summing block, and drives that block's amps, offsets and phasewords inputs.

## Interface
- TIMEOUT_CYCLES, 1024: idle cycles allowed between bytes of one frame; 0 disables the timeout.
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  8  command/payload byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- amps  out  64  signed active amplitudes; channel k in [16k+15:16k].
- offsets  out  64  active offsets; same packing.
- phasewords  out  64  active phase words; same packing.
- committed  out  1  one-cycle pulse after a commit or clear.
- err  out  1  one-cycle pulse on a bad opcode, bad field or timeout.
- tx_data  out  8  readback byte; tied to 0 when readback is disabled.
- tx_valid  out  1  readback handshake; tied to 0 when readback is disabled.
- tx_ready  in  1  readback handshake; ignored when readback is disabled.

## Operation
Header byte layout:
- [7:6] opcode: 00 WRITE, 01 COMMIT, 10 READ, 11 CLEAR.
- [5:4] field: 00 amp, 01 offset, 10 phaseword, 11 invalid.
- [3:2] reserved; ignored.
- [1:0] channel.

Opcodes:
- WRITE: header followed by two payload bytes, MSB first. On acceptance of the LO byte, shadow[field][channel] = {hi, lo}.
- WRITE with field 11: both payload bytes are still consumed and discarded; err pulses on LO acceptance.
- COMMIT: no payload. Active registers take all shadow registers at once.
- CLEAR: no payload. All shadow and active registers go to 0, and committed pulses.
- READ: see Configuration.

State machine:
- IDLE → HI on a WRITE header.
- HI → LO on the next accepted byte.
- LO → IDLE on the next accepted byte.
- COMMIT, CLEAR and invalid headers stay in IDLE.
- READ adds the states RD_HI and RD_LO.

Frame timeout:
- In HI or LO, a counter counts cycles with no accepted byte.
- When it reaches TIMEOUT_CYCLES: return to IDLE, pulse err, leave the shadow unchanged.
- The counter clears on every accepted byte and whenever the state is IDLE.

Other rules:
- in_ready = 1 in IDLE, HI and LO; 0 in RD_HI and RD_LO.
- Data is passed through as raw bits; no arithmetic or saturation.
- Amplitudes are two's complement and are not reinterpreted.

## Timing
Reset values:
- All outputs 0, except in_ready = 1.
- State IDLE; all shadow and active registers 0.

Latency:
- A shadow write is visible to a COMMIT accepted on the next cycle or later; back-to-back WRITE LO then COMMIT header is legal.
- Active buses change on the edge that accepts the COMMIT or CLEAR byte.
- committed and err are high for exactly the cycle after that edge.
- Throughput: one byte per cycle; a full WRITE frame takes 3 cycles.

Edge cases:
- Reset asserted mid-frame: state returns to IDLE immediately and the partial frame is lost.
- The timeout expiring on the same cycle a byte is accepted: the byte wins and the counter clears.
- Any WRITE not followed by a COMMIT leaves the outputs unchanged indefinitely.

## Configuration
The feature is controlled by WAVE_PARAM_READBACK_EN.

Defined:
- READ moves IDLE → RD_HI.
- tx_data = active[field][channel][15:8] with tx_valid = 1; on tx_ready go to RD_LO.
- RD_LO sends [7:0]; on tx_ready return to IDLE.
- READ with field 11 returns 0x0000 and pulses err.

Undefined:
- The READ opcode is invalid: err pulses, no bytes are consumed beyond the header, and the state stays IDLE.
- tx_data and tx_valid are held at 0.

## Structure
- Package wave_param_pkg holds:
  - opcode and field encodings;
  - state enum;
  - CH_COUNT = 4;
  - WORD_W = 16.
- Sub-module wave_param_regbank holds the 12 shadow and 12 active 16-bit registers, with write, commit and clear inputs and the packed 64-bit output buses.
- The top level contains the FSM, the timeout counter and readback.

## Test plan
- Reset, then WRITE amp ch2 = 0x8001, then COMMIT → amps[47:32] = 0x8001, all other bits 0; committed pulses 1 cycle after the COMMIT edge.
- WRITE phaseword ch0 = 0x1234 with no COMMIT → phasewords stays 0; a later COMMIT → phasewords[15:0] = 0x1234.
- Header 0x30 (WRITE, field 11) with payload 0xAA 0x55 → err pulses once; no register changes; the next WRITE decodes correctly.
- WRITE header and HI byte, then idle for 1024 cycles → err pulses and state is IDLE; the next byte is treated as a header.
- Set offsets on all 4 channels, COMMIT, then CLEAR → all three buses read 0 on the cycle after CLEAR; committed pulses.
- With WAVE_PARAM_READBACK_EN: READ amp ch2 after the first test → tx bytes 0x80 then 0x01, in_ready = 0 until the second tx_ready; with the macro undefined → err pulses and tx_valid stays 0.

Source files
------------

// File: rtl/wave_param_pkg.sv
// Shared encodings, state enum and sizing for the wave parameter loader.
package wave_param_pkg;

  localparam int CH_COUNT    = 4;
  localparam int WORD_W      = 16;
  localparam int FIELD_COUNT = 3;
  localparam int BUS_W       = CH_COUNT * WORD_W;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_COMMIT = 2'b01,
    OP_READ   = 2'b10,
    OP_CLEAR  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    FLD_AMP   = 2'b00,
    FLD_OFF   = 2'b01,
    FLD_PHASE = 2'b10,
    FLD_BAD   = 2'b11
  } field_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_RD_HI,
    ST_RD_LO
  } state_e;

endpackage

// File: rtl/wave_param_regbank.sv
// Shadow/active register bank; commit copies every shadow to active at once
// so all channels of the summing block update on the same edge.
module wave_param_regbank
  import wave_param_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  field_e            i_field,
  input  logic [1:0]        i_ch,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_commit,
  input  logic              i_clear,
  output logic [BUS_W-1:0]  o_amps,
  output logic [BUS_W-1:0]  o_offsets,
  output logic [BUS_W-1:0]  o_phasewords
);

  logic [WORD_W-1:0] r_sh  [FIELD_COUNT][CH_COUNT];
  logic [WORD_W-1:0] r_act [FIELD_COUNT][CH_COUNT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int f = 0; f < FIELD_COUNT; f++) begin
        for (int c = 0; c < CH_COUNT; c++) begin
          r_sh[f][c]  <= '0;
          r_act[f][c] <= '0;
        end
      end
    end else if (i_clear) begin
      for (int f = 0; f < FIELD_COUNT; f++) begin
        for (int c = 0; c < CH_COUNT; c++) begin
          r_sh[f][c]  <= '0;
          r_act[f][c] <= '0;
        end
      end
    end else begin
      if (i_commit) begin
        r_act <= r_sh;
      end
      for (int f = 0; f < FIELD_COUNT; f++) begin
        if (i_wr && int'(i_field) == f) begin
          r_sh[f][i_ch] <= i_data;
        end
      end
    end
  end

  always_comb begin
    o_amps       = '0;
    o_offsets    = '0;
    o_phasewords = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      o_amps[c*WORD_W +: WORD_W]       = r_act[0][c];
      o_offsets[c*WORD_W +: WORD_W]    = r_act[1][c];
      o_phasewords[c*WORD_W +: WORD_W] = r_act[2][c];
    end
  end

endmodule

// File: rtl/wave_param_loader.sv
// Byte-stream command decoder feeding the wave parameter register bank.
// Define WAVE_PARAM_READBACK_EN to enable the READ opcode and tx port.
module wave_param_loader
  import wave_param_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BUS_W-1:0] amps,
  output logic [BUS_W-1:0] offsets,
  output logic [BUS_W-1:0] phasewords,
  output logic             committed,
  output logic             err,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;
  field_e      r_field;
  logic [1:0]  r_ch;
  logic [7:0]  r_hi;
  logic [31:0] r_tcnt;
  logic        r_committed;
  logic        r_err;

  logic        w_acc;
  logic        w_busy;
  logic        w_tmo;
  logic        w_wr;
  logic        w_commit;
  logic        w_clear;
  logic        w_err_set;
  opcode_e     w_op;
  field_e      w_hfield;

  assign w_acc    = in_valid && in_ready;
  assign w_op     = opcode_e'(in_data[7:6]);
  assign w_hfield = field_e'(in_data[5:4]);
  assign w_busy   = (r_state == ST_HI) || (r_state == ST_LO);
  // Only an idle cycle can expire the frame; an accepted byte always wins.
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && w_busy && !w_acc &&
                    (r_tcnt == TMO_LAST);

  assign committed = r_committed;
  assign err       = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc && w_op == OP_WRITE) begin
          w_next = ST_HI;
        end
`ifdef WAVE_PARAM_READBACK_EN
        if (w_acc && w_op == OP_READ) begin
          w_next = ST_RD_HI;
        end
`endif
      end
      ST_HI: begin
        if (w_acc)      w_next = ST_LO;
        else if (w_tmo) w_next = ST_IDLE;
      end
      ST_LO: begin
        if (w_acc || w_tmo) w_next = ST_IDLE;
      end
      ST_RD_HI: begin
        if (tx_ready) w_next = ST_RD_LO;
      end
      ST_RD_LO: begin
        if (tx_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef WAVE_PARAM_READBACK_EN
  logic [WORD_W-1:0] w_rd_word;

  always_comb begin
    w_rd_word = '0;
    unique case (r_field)
      FLD_AMP:   w_rd_word = amps[{r_ch, 4'h0} +: WORD_W];
      FLD_OFF:   w_rd_word = offsets[{r_ch, 4'h0} +: WORD_W];
      FLD_PHASE: w_rd_word = phasewords[{r_ch, 4'h0} +: WORD_W];
      default:   w_rd_word = '0;
    endcase
  end
`else
  logic w_unused_tx_ready;
  assign w_unused_tx_ready = tx_ready;
`endif

  always_comb begin
    in_ready  = 1'b0;
    w_wr      = 1'b0;
    w_commit  = 1'b0;
    w_clear   = 1'b0;
    w_err_set = w_tmo;
    tx_valid  = 1'b0;
    tx_data   = '0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_acc) begin
          unique case (w_op)
            OP_WRITE:  ;
            OP_COMMIT: w_commit = 1'b1;
            OP_CLEAR:  w_clear  = 1'b1;
`ifdef WAVE_PARAM_READBACK_EN
            OP_READ:   w_err_set = (w_hfield == FLD_BAD);
`else
            OP_READ:   w_err_set = 1'b1;
`endif
            default:   ;
          endcase
        end
      end
      ST_HI: begin
        in_ready = 1'b1;
      end
      ST_LO: begin
        in_ready = 1'b1;
        if (w_acc) begin
          if (r_field == FLD_BAD) w_err_set = 1'b1;
          else                    w_wr      = 1'b1;
        end
      end
`ifdef WAVE_PARAM_READBACK_EN
      ST_RD_HI: begin
        tx_valid = 1'b1;
        tx_data  = w_rd_word[15:8];
      end
      ST_RD_LO: begin
        tx_valid = 1'b1;
        tx_data  = w_rd_word[7:0];
      end
`else
      ST_RD_HI: ;
      ST_RD_LO: ;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_field     <= FLD_AMP;
      r_ch        <= '0;
      r_hi        <= '0;
      r_tcnt      <= '0;
      r_committed <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_committed <= w_commit || w_clear;
      r_err       <= w_err_set;
      if (r_state == ST_IDLE && w_acc) begin
        r_field <= w_hfield;
        r_ch    <= in_data[1:0];
      end
      if (r_state == ST_HI && w_acc) begin
        r_hi <= in_data;
      end
      if (!w_busy || w_acc || w_tmo) begin
        r_tcnt <= '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
    end
  end

  wave_param_regbank u_bank (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_wr         (w_wr),
    .i_field      (r_field),
    .i_ch         (r_ch),
    .i_data       ({r_hi, in_data}),
    .i_commit     (w_commit),
    .i_clear      (w_clear),
    .o_amps       (amps),
    .o_offsets    (offsets),
    .o_phasewords (phasewords)
  );

endmodule

// File: tb/tb_wave_param_loader.sv
// Directed bench for wave_param_loader with a commit/err scoreboard.
// Covers readback when WAVE_PARAM_READBACK_EN is defined.
module tb_wave_param_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] amps;
  logic [63:0] offsets;
  logic [63:0] phasewords;
  logic        committed;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]  m_sh  [3][4];
  logic [15:0]  m_act [3][4];
  logic [191:0] busq [$];
  string        errq [$];

  always #5 clk = ~clk;

  wave_param_loader #(.TIMEOUT_CYCLES(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .committed  (committed),
    .err        (err),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] pack();
    logic [191:0] v;
    v = '0;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++)
        v[f*64 + c*16 +: 16] = m_act[f][c];
    return v;
  endfunction

  task automatic model_zero();
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) begin
        m_sh[f][c]  = '0;
        m_act[f][c] = '0;
      end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk("in_ready_at_send", in_ready, 1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wr(input int f, input int c, input logic [15:0] v);
    logic [7:0] h;
    h = {2'b00, 2'(f), 2'b00, 2'(c)};
    send(h);
    send(v[15:8]);
    if (f == 3) errq.push_back("bad_field");
    else        m_sh[f][c] = v;
    send(v[7:0]);
  endtask

  task automatic do_commit();
    m_act = m_sh;
    busq.push_back(pack());
    send(8'h40);
  endtask

  task automatic do_clear();
    model_zero();
    busq.push_back(pack());
    send(8'hC0);
  endtask

  // Scoreboard: every committed/err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (committed) begin
        chk("committed_expected", 32'(busq.size() != 0), 1);
        if (busq.size() != 0)
          chk("committed_buses", {phasewords, offsets, amps},
              busq.pop_front());
      end
      if (err) begin
        chk("err_expected", 32'(errq.size() != 0), 1);
        if (errq.size() != 0) void'(errq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ready = 1'b0;
    reset    = 1'b1;
    model_zero();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("rst_amps", amps, 0);
    chk("rst_offsets", offsets, 0);
    chk("rst_phase", phasewords, 0);
    chk("rst_committed", committed, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);

    wr(0, 2, 16'h8001);
    chk("amps_before_commit", amps, 0);
    do_commit();
    chk("amps_ch2", amps, 64'h8001 << 32);
    chk("commit_pulse", committed, 1);
    @(posedge clk); #1;
    chk("commit_pulse_end", committed, 0);

`ifdef WAVE_PARAM_READBACK_EN
    send(8'h82);
    chk("rd_hi_valid", tx_valid, 1);
    chk("rd_hi_data", tx_data, 8'h80);
    chk("rd_hi_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rd_stall_data", tx_data, 8'h80);
    chk("rd_stall_ready", in_ready, 0);
    @(negedge clk) tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_lo_valid", tx_valid, 1);
    chk("rd_lo_data", tx_data, 8'h01);
    chk("rd_lo_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rd_done_valid", tx_valid, 0);
    chk("rd_done_ready", in_ready, 1);
    @(negedge clk) tx_ready = 1'b0;
    errq.push_back("read_bad_field");
    send(8'hB2);
    chk("rd_bad_err", err, 1);
    chk("rd_bad_hi", tx_data, 0);
    @(negedge clk) tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_bad_lo", tx_data, 0);
    @(posedge clk); #1;
    chk("rd_bad_done", in_ready, 1);
    @(negedge clk) tx_ready = 1'b0;
`else
    errq.push_back("read_disabled");
    send(8'h82);
    chk("rd_dis_err", err, 1);
    chk("rd_dis_tx_valid", tx_valid, 0);
    chk("rd_dis_in_ready", in_ready, 1);
`endif

    wr(2, 0, 16'h1234);
    repeat (5) @(posedge clk);
    #1;
    chk("phase_no_commit", phasewords, 0);
    do_commit();
    chk("phase_ch0", phasewords, 64'h1234);
    chk("amps_kept", amps, 64'h8001 << 32);

    wr(3, 0, 16'hAA55);
    chk("bad_field_err", err, 1);
    chk("bad_field_buses", {phasewords, offsets, amps}, pack());
    wr(1, 1, 16'h00FF);
    do_commit();
    chk("offset_ch1", offsets, 64'h00FF << 16);

    errq.push_back("timeout");
    send(8'h11);
    send(8'hAB);
    n = 0;
    while (!err && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_cycles", n, 1024);
    do_commit();
    chk("after_timeout_commit", committed, 1);
    chk("after_timeout_offsets", offsets, 64'h00FF << 16);

    wr(1, 0, 16'h1111);
    wr(1, 1, 16'h2222);
    wr(1, 2, 16'h3333);
    wr(1, 3, 16'hFFFE);
    do_commit();
    chk("offsets_all", offsets, 64'hFFFE_3333_2222_1111);
    do_clear();
    chk("clear_committed", committed, 1);
    chk("clear_amps", amps, 0);
    chk("clear_offsets", offsets, 0);
    chk("clear_phase", phasewords, 0);

    for (int i = 0; i < 4; i++)
      wr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
         16'($urandom));
    do_commit();
    chk("random_buses", {phasewords, offsets, amps}, pack());

    send(8'h01);
    send(8'h12);
    @(negedge clk) reset = 1'b1;
    model_zero();
    #1;
    chk("midframe_rst_amps", amps, 0);
    @(negedge clk) reset = 1'b0;
    do_commit();
    chk("midframe_rst_commit", committed, 1);
    chk("midframe_rst_buses", {phasewords, offsets, amps}, 0);

    repeat (3) @(negedge clk);
    chk("pending_commits", busq.size(), 0);
    chk("pending_errs", errq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
